// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone DMA copy master.
package wb_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_GAP,
    WR,
    WR_GAP
  } wb_dma_state_t;

  localparam logic [3:0]  WB_SEL_WORD = 4'hF;
  localparam logic [31:0] WB_ADR_STEP = 32'd4;

endpackage

// File: rtl/n_bit_reg.sv
// Generic N-bit register with synchronous active-high reset and write enable.
module n_bit_reg #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wen_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (wen_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/wb_dma_watchdog.sv
// Bus watchdog: counts consecutive strobe cycles without ack, flags expiry.
// Compiled only when WB_DMA_TIMEOUT_EN is defined.
`ifdef WB_DMA_TIMEOUT_EN
module wb_dma_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || ack_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fires on the edge that would bring the count to TIMEOUT_CYC.
  assign expire_o = active_i && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/wb_dma_copy_master.sv
// Wishbone classic master copying LEN words from src to dst via alternating read/write.
// Optional bus watchdog abort enabled by defining WB_DMA_TIMEOUT_EN.
module wb_dma_copy_master
  import wb_dma_pkg::*;
#(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [31:0]      adr_o,
  output logic [3:0]       sel_o,
  output logic [31:0]      dat_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i
);

  wb_dma_state_t    state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             rd_wen;
  logic             unused_adr_lsb;

  assign unused_adr_lsb = ^{src_adr_i[1:0], dst_adr_i[1:0]};

`ifdef WB_DMA_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_expire;

  wb_dma_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (cyc_o),
    .ack_i    (ack_i),
    .expire_o (wd_expire)
  );

  assign err_o = err_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
`ifdef WB_DMA_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef WB_DMA_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (len_i != '0) begin
            src_d   = {src_adr_i[31:2], 2'b00};
            dst_d   = {dst_adr_i[31:2], 2'b00};
            rem_d   = len_i;
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD:     if (ack_i) state_d = RD_GAP;
      RD_GAP: state_d = WR;
      WR: begin
        if (ack_i) begin
          src_d = src_q + WB_ADR_STEP;
          dst_d = dst_q + WB_ADR_STEP;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WR_GAP;
          end
        end
      end
      WR_GAP:  state_d = RD;
      default: state_d = IDLE;
    endcase
`ifdef WB_DMA_TIMEOUT_EN
    if (wd_expire) begin
      state_d = IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
`ifdef WB_DMA_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
`ifdef WB_DMA_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rd_wen = (state_q == RD) && ack_i;

  n_bit_reg #(.N(32)) u_data_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wen_i (rd_wen),
    .d_i   (dat_i),
    .q_o   (dat_o)
  );

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign cyc_o  = (state_q == RD) || (state_q == WR);
  assign stb_o  = cyc_o;
  assign we_o   = (state_q == WR);
  assign adr_o  = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : '0;
  assign sel_o  = WB_SEL_WORD;

endmodule

// File: tb/tb_wb_dma_copy_master.sv
// Self-checking bench: random-wait WB slave memory plus a sequential copy model.
module tb_wb_dma_copy_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src_adr_i = '0;
  logic [31:0] dst_adr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;

  wb_dma_copy_master #(.LEN_W(16), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc_cnt = 0;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } op_t;

  op_t         log_q[$];
  logic [31:0] smem[logic [31:0]];
  int          wait_mode = 1;     // -1 random 0..3, -2 never ack, >=0 fixed waits
  bit          spur_en = 1'b0;
  bit          in_txn = 1'b0;
  int          wcnt = 0;
  int unsigned lat_sum = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction

  // Slave decides ack at the falling edge so the DUT samples it cleanly.
  always @(negedge clk_i) begin
    ack_i = 1'b0;
    dat_i = $urandom;
    if (cyc_o && stb_o) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        wcnt = (wait_mode == -1) ? int'($urandom_range(0, 3)) : (wait_mode < 0 ? 0 : wait_mode);
        lat_sum += wcnt + 1;
      end
      if (wait_mode != -2 && wcnt == 0) begin
        ack_i  = 1'b1;
        in_txn = 1'b0;
        if (we_o) begin
          smem[adr_o] = dat_o;
          log_q.push_back('{1'b1, adr_o, dat_o});
        end else begin
          dat_i = slave_rd(adr_o);
          log_q.push_back('{1'b0, adr_o, dat_i});
        end
      end else if (wcnt > 0) begin
        wcnt--;
      end
    end else begin
      in_txn = 1'b0;
      if (spur_en && $urandom_range(0, 3) == 0) ack_i = 1'b1;
    end
  end

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input int wm, input bit inject);
    op_t exp_q[$];
    logic [31:0] mmem[logic [31:0]];
    logic [31:0] a_s, a_d, v;
    int unsigned first, td, bad, nd;
    bit got;
    mmem = smem;
    a_s = {s[31:2], 2'b00};
    a_d = {d[31:2], 2'b00};
    for (int unsigned i = 0; i < l; i++) begin
      v = mmem.exists(a_s) ? mmem[a_s] : init_val(a_s);
      exp_q.push_back('{1'b0, a_s, v});
      exp_q.push_back('{1'b1, a_d, v});
      mmem[a_d] = v;
      a_s += 32'd4;
      a_d += 32'd4;
    end
    log_q.delete();
    lat_sum = 0;
    wait_mode = wm;
    @(negedge clk_i);
    start_i = 1'b1; src_adr_i = s; dst_adr_i = d; len_i = l;
    @(negedge clk_i);
    start_i = 1'b0; src_adr_i = $urandom; dst_adr_i = $urandom; len_i = 16'($urandom_range(1, 100));
    check("start_err_clr", err_o, 0);
    if (l == 0) begin
      check("len0_done", {busy_o, done_o, cyc_o}, 3'b010);
      bad = 0;
      repeat (4) begin
        @(negedge clk_i);
        if (busy_o || done_o || cyc_o) bad++;
      end
      check("len0_quiet", bad, 0);
      return;
    end
    check("first_stb", {busy_o, cyc_o, we_o, adr_o}, {2'b11, 1'b0, s[31:2], 2'b00});
    first = cyc_cnt;
    td = 0;
    bad = 0;
    got = 1'b0;
    for (int unsigned n = 0; n < 1000; n++) begin
      if (done_o) begin
        got = 1'b1;
        td = cyc_cnt;
        break;
      end
      if (!busy_o || cyc_o !== stb_o || sel_o !== 4'hF || adr_o[1:0] !== 2'b00) bad++;
      start_i = inject && (n == 5);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check("done_seen", got, 1);
    if (got) check("latency", td - first + 1, lat_sum + 2 * l);
    check("done_state", {busy_o, err_o, cyc_o}, 3'b000);
    check("bus_proto", bad, 0);
    check("op_count", log_q.size(), exp_q.size());
    for (int unsigned i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check("op", log_q[i], exp_q[i]);
    nd = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o || cyc_o) nd++;
    end
    check("post_quiet", nd, 0);
  endtask

  task automatic reset_mid_test();
    int unsigned nd;
    bit got;
    wait_mode = 1;
    @(negedge clk_i);
    start_i = 1'b1; src_adr_i = 32'h0000_5000; dst_adr_i = 32'h0000_6000; len_i = 16'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    got = 1'b0;
    for (int unsigned n = 0; n < 200; n++) begin
      if (cyc_o && we_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check("rst_reach_wr", got, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid", {busy_o, done_o, err_o, cyc_o, stb_o}, 5'b0);
    rst_i = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o || cyc_o || busy_o) nd++;
    end
    check("rst_quiet", nd, 0);
  endtask

`ifdef WB_DMA_TIMEOUT_EN
  task automatic timeout_test();
    int unsigned stb_n;
    bit got;
    wait_mode = -2;
    @(negedge clk_i);
    start_i = 1'b1; src_adr_i = 32'h0000_7000; dst_adr_i = 32'h0000_8000; len_i = 16'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    stb_n = 0;
    got = 1'b0;
    for (int unsigned n = 0; n < 100; n++) begin
      if (done_o) begin
        got = 1'b1;
        break;
      end
      if (stb_o) stb_n++;
      @(negedge clk_i);
    end
    check("to_done", got, 1);
    check("to_stb_cycles", stb_n, 8);
    check("to_err", {err_o, busy_o, cyc_o}, 3'b100);
    repeat (2) @(negedge clk_i);
    check("to_err_sticky", {err_o, done_o}, 2'b10);
    run_xfer(32'h0000_0400, 32'h0000_0500, 16'd1, 1, 1'b0);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk_i);
    check("reset_vals", {busy_o, done_o, err_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o},
          {6'b0, 4'hF, 64'b0});
    rst_i = 1'b0;

    smem[32'h100] = 32'hDEAD_BEEF;
    run_xfer(32'h0000_0100, 32'h0000_0200, 16'd1, 1, 1'b0);
    check("t1_dst_word", smem[32'h200], 32'hDEAD_BEEF);
    run_xfer(32'h0000_1000, 32'h0000_2000, 16'd4, 1, 1'b0);
    run_xfer(32'h0000_3000, 32'h0000_4000, 16'd0, 1, 1'b0);
    run_xfer(32'h0000_3001, 32'h0000_4002, 16'd3, 1, 1'b1);
    run_xfer(32'hFFFF_FFFC, 32'h0000_0010, 16'd2, -1, 1'b0);
    reset_mid_test();

    spur_en = 1'b1;
    for (int unsigned k = 0; k < 20; k++) begin
      run_xfer($urandom, $urandom, 16'($urandom_range(1, 6)),
               ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end
    spur_en = 1'b0;

`ifdef WB_DMA_TIMEOUT_EN
    timeout_test();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
